joypad_port: RTL and testbench

- CPU-side responder for the NES controller registers $4016/$4017, together with a serial scanner that polls two physical NES pads.
- Sits on the CPU bus next to the PPU register decode, on the same `ea`/`dout`/`wreq`/`rd` signals.
- Returns controller bits to the CPU through the top-level read mux.
- Runs on the 100 MHz `clk`; CPU cycles are qualified by `cpuclk`.

---
 rtl/joypad_port.sv | 170 +++++++++++++++++
 tb/tb_joypad_port.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/joypad_port.sv
// NES controller port: CPU-side $4016/$4017 responder plus a serial scanner that
// polls two pads at a fixed rate and keeps a debounced snapshot of both.
module joypad_port #(
    parameter int          SCAN_PERIOD = 1666666,
    parameter int          HALF        = 600,
    parameter logic [15:0] ADDR1       = 16'h4016,
    parameter logic [15:0] ADDR2       = 16'h4017
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpuclk,
    input  logic [15:0] ea,
    input  logic [7:0]  dout,
    input  logic        wreq,
    input  logic        rd,
    output logic [7:0]  joy_dout,
    output logic        joy_sel,
    output logic        pad_latch,
    output logic        pad_clk,
    input  logic        pad_data1,
    input  logic        pad_data2
);
    localparam int PW = $clog2(SCAN_PERIOD + 1);
    localparam int HW = $clog2(HALF + 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(SCAN_PERIOD - 1);
    localparam logic [HW-1:0] HALF_LAST   = HW'(HALF - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LATCH  = 3'd1;
    localparam logic [2:0] S_SAMPLE = 3'd2;
    localparam logic [2:0] S_CLKLO  = 3'd3;
    localparam logic [2:0] S_CLKHI  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic          r_cpuclk_d;
    logic          r_strobe;
    logic [7:0]    r_sr1, r_sr2;
    logic [7:0]    r_pad_state1, r_pad_state2;
    logic [7:0]    r_temp1, r_temp2;
    logic [2:0]    r_state;
    logic [2:0]    r_idx;
    logic [PW-1:0] r_period_cnt;
    logic [HW-1:0] r_half_cnt;
    logic          r_latch;
    logic          r_pclk;

    logic       w_cyc_end;
    logic       w_hit1, w_hit2;
    logic       w_scan_start;
    logic       w_half_done;
    logic [7:0] w_joy_dout;

    assign w_cyc_end    = cpuclk & ~r_cpuclk_d;
    assign w_hit1       = (ea == ADDR1);
    assign w_hit2       = (ea == ADDR2);
    assign w_scan_start = (r_period_cnt == PERIOD_LAST);
    assign w_half_done  = (r_half_cnt == HALF_LAST);

    always_comb begin
        w_joy_dout = 8'h40;
        if (w_hit1)
            w_joy_dout[0] = r_sr1[0];
        else if (w_hit2)
            w_joy_dout[0] = r_sr2[0];
    end

    assign joy_dout  = w_joy_dout;
    assign joy_sel   = rd & (w_hit1 | w_hit2);
    assign pad_latch = r_latch;
    assign pad_clk   = r_pclk;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cpuclk_d   <= 1'b0;
            r_period_cnt <= '0;
        end else begin
            r_cpuclk_d   <= cpuclk;
            r_period_cnt <= w_scan_start ? '0 : r_period_cnt + 1'b1;
        end
    end

    // CPU side: writes to ADDR2 belong to the APU and are deliberately ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_strobe <= 1'b0;
            r_sr1    <= '0;
            r_sr2    <= '0;
        end else begin
            if (w_cyc_end && wreq && w_hit1)
                r_strobe <= dout[0];
            if (r_strobe) begin
                r_sr1 <= r_pad_state1;
                r_sr2 <= r_pad_state2;
            end else begin
                if (w_cyc_end && rd && w_hit1)
                    r_sr1 <= {1'b1, r_sr1[7:1]};
                if (w_cyc_end && rd && w_hit2)
                    r_sr2 <= {1'b1, r_sr2[7:1]};
            end
        end
    end

    // Scanner: pad_state only changes in DONE, so an aborted scan leaves it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_half_cnt   <= '0;
            r_latch      <= 1'b0;
            r_pclk       <= 1'b1;
            r_temp1      <= '0;
            r_temp2      <= '0;
            r_pad_state1 <= '0;
            r_pad_state2 <= '0;
        end else begin
            r_half_cnt <= w_half_done ? '0 : r_half_cnt + 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_half_cnt <= '0;
                    if (w_scan_start) begin
                        r_latch <= 1'b1;
                        r_state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    if (w_half_done) begin
                        r_latch <= 1'b0;
                        r_idx   <= '0;
                        r_state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    if (w_half_done) begin
                        r_temp1[r_idx] <= ~pad_data1;
                        r_temp2[r_idx] <= ~pad_data2;
                        if (r_idx == 3'd7) begin
                            r_state <= S_DONE;
                        end else begin
                            r_pclk  <= 1'b0;
                            r_state <= S_CLKLO;
                        end
                    end
                end
                S_CLKLO: begin
                    if (w_half_done) begin
                        r_pclk  <= 1'b1;
                        r_state <= S_CLKHI;
                    end
                end
                S_CLKHI: begin
                    r_half_cnt <= '0;
                    r_idx      <= r_idx + 1'b1;
                    r_state    <= S_SAMPLE;
                end
                S_DONE: begin
                    r_half_cnt   <= '0;
                    r_pad_state1 <= r_temp1;
                    r_pad_state2 <= r_temp2;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_half_cnt <= '0;
                    r_latch    <= 1'b0;
                    r_pclk     <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_joypad_port.sv
// Directed bench for joypad_port: decode table, CPU read sequences and scanner timing.
module tb_joypad_port;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpuclk = 1'b0;
    logic [15:0] ea = 16'h0000;
    logic [7:0]  dout = 8'h00;
    logic        wreq = 1'b0;
    logic        rd = 1'b0;
    logic [7:0]  joy_dout;
    logic        joy_sel;
    logic        pad_latch;
    logic        pad_clk;
    logic        pad_data1;
    logic        pad_data2;

    int tests = 0;
    int fails = 0;

    logic [7:0] btn1 = 8'h09;
    logic [7:0] btn2 = 8'h80;

    joypad_port #(.SCAN_PERIOD(2000), .HALF(4)) dut (
        .clk(clk), .reset(reset), .cpuclk(cpuclk), .ea(ea), .dout(dout),
        .wreq(wreq), .rd(rd), .joy_dout(joy_dout), .joy_sel(joy_sel),
        .pad_latch(pad_latch), .pad_clk(pad_clk),
        .pad_data1(pad_data1), .pad_data2(pad_data2)
    );

    always #5 clk = ~clk;

    // Pad model: 4021-style shift register, active-low outputs, A first.
    int   pcnt = 0;
    logic pm_prev = 1'b1;
    always @(posedge clk) begin
        if (pad_latch) pcnt = 0;
        else if (pad_clk && !pm_prev) pcnt = pcnt + 1;
        pm_prev = pad_clk;
    end
    assign pad_data1 = (pcnt < 8) ? ~btn1[pcnt[2:0]] : 1'b0;
    assign pad_data2 = (pcnt < 8) ? ~btn2[pcnt[2:0]] : 1'b0;

    int   latch_cyc = 0;
    int   clk_fall = 0;
    int   clk_rise = 0;
    logic mon_prev = 1'b1;
    always @(posedge clk) begin
        if (pad_latch) latch_cyc = latch_cyc + 1;
        if (mon_prev && !pad_clk) clk_fall = clk_fall + 1;
        if (!mon_prev && pad_clk) clk_rise = clk_rise + 1;
        mon_prev = pad_clk;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk); ea = a; rd = 1'b1; wreq = 1'b0;
        @(negedge clk); d = joy_dout; cpuclk = 1'b1;
        @(negedge clk); cpuclk = 1'b0; rd = 1'b0; ea = 16'h0000;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] v);
        @(negedge clk); ea = a; dout = v; wreq = 1'b1; rd = 1'b0;
        @(negedge clk); cpuclk = 1'b1;
        @(negedge clk); cpuclk = 1'b0; wreq = 1'b0; ea = 16'h0000;
    endtask

    task automatic wait_latch(input string name);
        for (int i = 0; i < 3000 && !pad_latch; i++) @(negedge clk);
        chk(name, 16'(pad_latch), 16'd1);
    endtask

    task automatic wait_rises(input int n, input string name);
        int snap;
        snap = clk_rise;
        for (int i = 0; i < 300 && (clk_rise - snap) < n; i++) @(negedge clk);
        chk(name, 16'(clk_rise - snap), 16'(n));
    endtask

    typedef struct {
        logic [15:0] ea;
        logic        rd;
        logic [7:0]  exp_dout;
        logic        exp_sel;
    } vec_t;

    initial begin
        vec_t       tbl[7];
        int         exp_b[10];
        logic [7:0] d;
        int         snap_l, snap_f;

        // After pad_state1=09 / pad_state2=80 are loaded through the strobe.
        tbl[0] = '{16'h4016, 1'b1, 8'h41, 1'b1};
        tbl[1] = '{16'h4017, 1'b1, 8'h40, 1'b1};
        tbl[2] = '{16'h4016, 1'b0, 8'h41, 1'b0};
        tbl[3] = '{16'h4017, 1'b0, 8'h40, 1'b0};
        tbl[4] = '{16'h4015, 1'b1, 8'h40, 1'b0};
        tbl[5] = '{16'h2002, 1'b1, 8'h40, 1'b0};
        tbl[6] = '{16'h0016, 1'b1, 8'h40, 1'b0};
        exp_b = '{1, 0, 0, 1, 0, 0, 0, 0, 1, 1};

        // Reset state
        repeat (5) @(negedge clk);
        ea = 16'h4016;
        #1;
        chk("rst_latch", 16'(pad_latch), 16'd0);
        chk("rst_clk", 16'(pad_clk), 16'd1);
        chk("rst_dout", 16'(joy_dout), 16'h0040);
        chk("rst_sel", 16'(joy_sel), 16'd0);
        @(negedge clk); reset = 1'b1; ea = 16'h0000;

        // First scan: latch width, clock pulses, captured state
        snap_l = latch_cyc; snap_f = clk_fall;
        wait_latch("scan1_start");
        repeat (150) @(negedge clk);
        chk("latch_width", 16'(latch_cyc - snap_l), 16'd4);
        chk("clk_pulses", 16'(clk_fall - snap_f), 16'd7);
        chk("pad_state1", 16'(dut.r_pad_state1), 16'h0009);
        chk("pad_state2", 16'(dut.r_pad_state2), 16'h0080);

        // Load shift registers via strobe, then combinational decode table
        bus_write(16'h4016, 8'h01);
        bus_write(16'h4016, 8'h00);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            ea = tbl[i].ea; rd = tbl[i].rd;
            #1;
            chk($sformatf("tbl%0d_dout", i), 16'(joy_dout), 16'(tbl[i].exp_dout));
            chk($sformatf("tbl%0d_sel", i), 16'(joy_sel), 16'(tbl[i].exp_sel));
        end
        @(negedge clk); rd = 1'b0; ea = 16'h0000;

        // Ten serial reads of pad 1
        for (int i = 0; i < 10; i++) begin
            bus_read(16'h4016, d);
            chk($sformatf("read1_%0d", i), 16'(d), 16'(8'h40 | 8'(exp_b[i])));
        end

        // Strobe held high: no shifting
        bus_write(16'h4016, 8'h01);
        for (int i = 0; i < 3; i++) begin
            bus_read(16'h4016, d);
            chk($sformatf("strobe_%0d", i), 16'(d), 16'h0041);
        end
        bus_write(16'h4016, 8'h00);

        // Pad 2 independence; a write to $4017 must not touch the strobe
        bus_write(16'h4017, 8'h01);
        for (int i = 0; i < 8; i++) begin
            bus_read(16'h4017, d);
            chk($sformatf("read2_%0d", i), 16'(d), (i == 7) ? 16'h0041 : 16'h0040);
        end
        bus_read(16'h4016, d);
        chk("pad1_after_pad2", 16'(d), 16'h0041);

        // Reset mid-scan during SAMPLE with idx=4
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        wait_latch("scan2_start");
        wait_rises(4, "scan2_rises");
        @(posedge clk); @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_latch", 16'(pad_latch), 16'd0);
        chk("mid_clk", 16'(pad_clk), 16'd1);
        chk("mid_state1", 16'(dut.r_pad_state1), 16'h0000);
        @(negedge clk); @(negedge clk); reset = 1'b1;
        repeat (150) @(negedge clk);
        chk("abort_state1", 16'(dut.r_pad_state1), 16'h0000);
        snap_f = clk_fall;
        wait_latch("scan3_start");
        repeat (150) @(negedge clk);
        chk("rescan_pulses", 16'(clk_fall - snap_f), 16'd7);
        chk("rescan_state1", 16'(dut.r_pad_state1), 16'h0009);
        chk("rescan_state2", 16'(dut.r_pad_state2), 16'h0080);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
